uart_ahb_loader: RTL and testbench
==================================

# uart_ahb_loader

UART-driven AHB-lite bus master for loading and inspecting memory over the serial port. Byte frames arriving from the UART receiver are parsed into single-word AHB-lite reads and writes. Each transfer is issued on the system bus as an initiator, and a response is returned through the UART transmitter. The block is a second bus master, placed alongside the core behind a bus arbiter; it is the initiator end of the same AHB-lite protocol the memory and peripheral slaves respond to.

## Interface
- FRAME_TIMEOUT, 1_000_000: clock cycles without a byte, mid-frame, before the parser abandons the frame.
- HCLK  in  1  single clock; all logic is on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- tx_data  out  8  byte to transmit; stable from the tx_en cycle until tx_busy falls.
- tx_en  out  1  one-cycle transmit request.
- tx_busy  in  1  high while the UART transmitter is shifting.
- HADDR  out  32  bus address; bits [1:0] always 0.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HSIZE  out  3  constant 3'b010.
- HBURST  out  3  constant 3'b000.
- HPROT  out  4  constant 4'b0011.
- HMASTLOCK  out  1  constant 0.
- HWRITE  out  1  transfer direction.
- HWDATA  out  32  write data.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer-complete / wait-state indication.
- HRESP  in  1  1 = ERROR response.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse when a transfer completes with an error.

## Operation
Frames (all multi-byte fields are sent MSB first):
- Write frame: 0x57 'W', A3 A2 A1 A0, D3 D2 D1 D0.
  - Reply 0x4B 'K' on OKAY, 0x45 'E' on ERROR.
- Read frame: 0x52 'R', A3 A2 A1 A0.
  - Reply is HRDATA[31:24], [23:16], [15:8], [7:0] on OKAY, or the single byte 0x45 on ERROR.
- Any other byte in IDLE is discarded; the parser stays in IDLE.
- Address bits [1:0] are forced to 0 before issue.

States:
- IDLE: waits for a command byte.
- GET_ADDR: collects 4 address bytes, shifted in MSB first.
- GET_DATA: write frames only; collects 4 data bytes.
- AHB_ADDR: drives HTRANS=NONSEQ with HADDR and HWRITE, held until an edge with HREADY=1.
- AHB_DATA: drives HTRANS=IDLE, holding HWDATA for writes, until an edge with HREADY=1.
  - At that edge, HRDATA is captured.
  - An error is recorded if HRESP=1 at that edge or in any earlier AHB_DATA cycle.
- SEND: issues tx_en when tx_busy=0; one byte per request.
- WAIT_TX: ignores tx_busy for 1 cycle after tx_en, then waits for tx_busy=0.
  - Then moves to the next byte, or to IDLE after the last byte.

Boundary rules:
- Frame timeout: a counter runs only in GET_ADDR and GET_DATA and resets on every accepted byte. When it reaches FRAME_TIMEOUT the parser returns to IDLE with no bus activity and no reply.
- rx_valid in AHB_ADDR, AHB_DATA, SEND or WAIT_TX: the byte is dropped, with no state change.
- ERROR response: the master is already IDLE in the data phase, so no cancellation is needed. err pulses for one cycle at completion; the 'E' reply follows.
- HREADY low during the address phase: HADDR, HTRANS and HWRITE are held unchanged.
- Reset mid-operation: all state is cleared immediately.
  - Any bus transfer is abandoned, with HTRANS=IDLE asynchronously.
  - No partial reply is sent.

## Timing
- Reset values:
  - HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0.
  - tx_en=0, tx_data=0.
  - busy=0, err=0.
  - State IDLE.
- Address phase: the edge accepting the last frame byte (rx_valid=1) moves to AHB_ADDR; NONSEQ is visible in the next cycle.
- With zero wait states:
  - the address phase lasts 1 cycle;
  - the data phase lasts 1 cycle;
  - the first tx_en is asserted in the cycle after the data-phase completing edge, provided tx_busy=0.
- Each wait state (HREADY=0) extends its phase by exactly 1 cycle.
- tx_en is never asserted in two consecutive cycles. tx_data is updated in the same cycle as tx_en.
- HWDATA changes only on entry to AHB_DATA.

## Test plan
- Write frame 57 00 00 01 04 DE AD BE EF, zero-wait slave -> one NONSEQ with HADDR=0x00000104, HWRITE=1, then HWDATA=0xDEADBEEF; reply 0x4B; err never pulses.
- Read frame 52 20 00 00 07, slave returns 0x12345678 after 3 wait states -> HADDR=0x20000004; data phase 4 cycles long; replies 12 34 56 78 in order, each tx_en only after tx_busy falls.
- Write frame with a two-cycle ERROR response (HREADY=0/HRESP=1, then HREADY=1/HRESP=1) -> err pulses once; reply 0x45 only.
- Junk bytes 0x00 0xFF, then a valid read frame -> junk ignored; exactly one read issued.
- 57 00 00 (then silence for FRAME_TIMEOUT cycles), then a full read frame -> no write issued; the read executes normally.
- HRESETn low during AHB_DATA of a read -> HTRANS=00 and busy=0 immediately; no tx_en after release; the next frame works.

Source files
------------

// File: rtl/uart_ahb_loader_if.sv
// AHB-lite bus bundle between the UART loader (initiator) and the system bus.
interface uart_ahb_loader_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/uart_ahb_loader.sv
// UART-driven AHB-lite initiator: parses 'W'/'R' byte frames into single-word
// bus transfers and returns the reply bytes through the UART transmitter.
module uart_ahb_loader #(
    parameter int unsigned FRAME_TIMEOUT = 1_000_000
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    uart_ahb_loader_if.master ahb,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_busy,
    output logic              busy,
    output logic              err
);
    localparam int unsigned     TW           = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [TW-1:0]   TMAX         = TW'(FRAME_TIMEOUT);
    localparam logic [7:0]      CMD_W        = 8'h57;
    localparam logic [7:0]      CMD_R        = 8'h52;
    localparam logic [7:0]      RSP_K        = 8'h4B;
    localparam logic [7:0]      RSP_E        = 8'h45;
    localparam logic [1:0]      TRANS_IDLE   = 2'b00;
    localparam logic [1:0]      TRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        AHB_ADDR = 3'd3,
        AHB_DATA = 3'd4,
        SEND     = 3'd5,
        WAIT_TX  = 3'd6
    } state_t;

    state_t        state_r, state_nx_s;
    logic          wr_r, wr_nx_s;
    logic [1:0]    cnt_r, cnt_nx_s;
    logic [31:0]   addr_r, addr_nx_s;
    logic [31:0]   wdata_r, wdata_nx_s;
    logic [TW-1:0] timer_r, timer_nx_s;
    logic [31:0]   haddr_r, haddr_nx_s;
    logic [1:0]    htrans_r, htrans_nx_s;
    logic          hwrite_r, hwrite_nx_s;
    logic [31:0]   hwdata_r, hwdata_nx_s;
    logic          err_seen_r, err_seen_nx_s;
    logic          err_r, err_nx_s;
    logic [31:0]   reply_r, reply_nx_s;
    logic [2:0]    left_r, left_nx_s;
    logic          tx_en_r, tx_en_nx_s;
    logic [7:0]    tx_data_r, tx_data_nx_s;
    logic          hold_r, hold_nx_s;
    logic          busy_r, busy_nx_s;
    logic          fail_s;
    logic [31:0]   reply_load_s;
    logic [2:0]    nbytes_s;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    // Next-state and next-output computation for the whole loader FSM.
    always_comb begin
        state_nx_s    = state_r;
        wr_nx_s       = wr_r;
        cnt_nx_s      = cnt_r;
        addr_nx_s     = addr_r;
        wdata_nx_s    = wdata_r;
        timer_nx_s    = timer_r;
        haddr_nx_s    = haddr_r;
        htrans_nx_s   = htrans_r;
        hwrite_nx_s   = hwrite_r;
        hwdata_nx_s   = hwdata_r;
        err_seen_nx_s = err_seen_r;
        err_nx_s      = 1'b0;
        reply_nx_s    = reply_r;
        left_nx_s     = left_r;
        tx_en_nx_s    = 1'b0;
        tx_data_nx_s  = tx_data_r;
        hold_nx_s     = hold_r;
        fail_s        = 1'b0;
        reply_load_s  = 32'h0000_0000;
        nbytes_s      = 3'd0;
        case (state_r)
            IDLE: begin
                timer_nx_s = {TW{1'b0}};
                cnt_nx_s   = 2'd0;
                if (rx_valid && ((rx_data == CMD_W) || (rx_data == CMD_R))) begin
                    wr_nx_s    = (rx_data == CMD_W);
                    state_nx_s = GET_ADDR;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    timer_nx_s = {TW{1'b0}};
                    addr_nx_s  = {addr_r[23:0], rx_data};
                    cnt_nx_s   = cnt_r + 2'd1;
                    if ((cnt_r == 2'd3) && wr_r) begin
                        state_nx_s = GET_DATA;
                    end else if (cnt_r == 2'd3) begin
                        state_nx_s  = AHB_ADDR;
                        haddr_nx_s  = word_align({addr_r[23:0], rx_data});
                        htrans_nx_s = TRANS_NONSEQ;
                        hwrite_nx_s = 1'b0;
                    end else begin
                        state_nx_s = GET_ADDR;
                    end
                end else if (timer_r == TMAX) begin
                    state_nx_s = IDLE;
                end else begin
                    timer_nx_s = timer_r + TW'(1);
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    timer_nx_s = {TW{1'b0}};
                    wdata_nx_s = {wdata_r[23:0], rx_data};
                    cnt_nx_s   = cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        state_nx_s  = AHB_ADDR;
                        haddr_nx_s  = word_align(addr_r);
                        htrans_nx_s = TRANS_NONSEQ;
                        hwrite_nx_s = 1'b1;
                    end else begin
                        state_nx_s = GET_DATA;
                    end
                end else if (timer_r == TMAX) begin
                    state_nx_s = IDLE;
                end else begin
                    timer_nx_s = timer_r + TW'(1);
                end
            end
            AHB_ADDR: begin
                if (ahb.HREADY) begin
                    state_nx_s    = AHB_DATA;
                    htrans_nx_s   = TRANS_IDLE;
                    err_seen_nx_s = 1'b0;
                    hwdata_nx_s   = wr_r ? wdata_r : hwdata_r;
                end else begin
                    state_nx_s = AHB_ADDR;
                end
            end
            AHB_DATA: begin
                if (ahb.HREADY) begin
                    // An ERROR seen in any wait cycle still fails the transfer.
                    fail_s   = err_seen_r | ahb.HRESP;
                    err_nx_s = fail_s;
                    if (fail_s) begin
                        reply_load_s = {RSP_E, 24'h00_0000};
                        nbytes_s     = 3'd1;
                    end else if (wr_r) begin
                        reply_load_s = {RSP_K, 24'h00_0000};
                        nbytes_s     = 3'd1;
                    end else begin
                        reply_load_s = ahb.HRDATA;
                        nbytes_s     = 3'd4;
                    end
                    if (!tx_busy) begin
                        tx_en_nx_s   = 1'b1;
                        tx_data_nx_s = reply_load_s[31:24];
                        reply_nx_s   = {reply_load_s[23:0], 8'h00};
                        left_nx_s    = nbytes_s - 3'd1;
                        hold_nx_s    = 1'b1;
                        state_nx_s   = WAIT_TX;
                    end else begin
                        reply_nx_s = reply_load_s;
                        left_nx_s  = nbytes_s;
                        state_nx_s = SEND;
                    end
                end else begin
                    err_seen_nx_s = err_seen_r | ahb.HRESP;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_en_nx_s   = 1'b1;
                    tx_data_nx_s = reply_r[31:24];
                    reply_nx_s   = {reply_r[23:0], 8'h00};
                    left_nx_s    = left_r - 3'd1;
                    hold_nx_s    = 1'b1;
                    state_nx_s   = WAIT_TX;
                end else begin
                    state_nx_s = SEND;
                end
            end
            WAIT_TX: begin
                // The transmitter may not raise tx_busy until a cycle after tx_en.
                hold_nx_s = 1'b0;
                if (hold_r) begin
                    state_nx_s = WAIT_TX;
                end else if (!tx_busy) begin
                    state_nx_s = (left_r == 3'd0) ? IDLE : SEND;
                end else begin
                    state_nx_s = WAIT_TX;
                end
            end
            default: begin
                state_nx_s  = IDLE;
                htrans_nx_s = TRANS_IDLE;
            end
        endcase
        busy_nx_s = (state_nx_s != IDLE);
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r    <= IDLE;
            wr_r       <= 1'b0;
            cnt_r      <= 2'd0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            timer_r    <= {TW{1'b0}};
            haddr_r    <= 32'h0000_0000;
            htrans_r   <= TRANS_IDLE;
            hwrite_r   <= 1'b0;
            hwdata_r   <= 32'h0000_0000;
            err_seen_r <= 1'b0;
            err_r      <= 1'b0;
            reply_r    <= 32'h0000_0000;
            left_r     <= 3'd0;
            tx_en_r    <= 1'b0;
            tx_data_r  <= 8'h00;
            hold_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            wr_r       <= wr_nx_s;
            cnt_r      <= cnt_nx_s;
            addr_r     <= addr_nx_s;
            wdata_r    <= wdata_nx_s;
            timer_r    <= timer_nx_s;
            haddr_r    <= haddr_nx_s;
            htrans_r   <= htrans_nx_s;
            hwrite_r   <= hwrite_nx_s;
            hwdata_r   <= hwdata_nx_s;
            err_seen_r <= err_seen_nx_s;
            err_r      <= err_nx_s;
            reply_r    <= reply_nx_s;
            left_r     <= left_nx_s;
            tx_en_r    <= tx_en_nx_s;
            tx_data_r  <= tx_data_nx_s;
            hold_r     <= hold_nx_s;
            busy_r     <= busy_nx_s;
        end
    end

    assign ahb.HADDR     = haddr_r;
    assign ahb.HTRANS    = htrans_r;
    assign ahb.HWRITE    = hwrite_r;
    assign ahb.HWDATA    = hwdata_r;
    assign ahb.HSIZE     = 3'b010;
    assign ahb.HBURST    = 3'b000;
    assign ahb.HPROT     = 4'b0011;
    assign ahb.HMASTLOCK = 1'b0;
    assign tx_en         = tx_en_r;
    assign tx_data       = tx_data_r;
    assign busy          = busy_r;
    assign err           = err_r;
endmodule

// File: tb/tb_uart_ahb_loader.sv
// Self-checking bench for uart_ahb_loader: table of frames plus hand sequences,
// with scoreboard queues for expected bus transfers and reply bytes.
module tb_uart_ahb_loader;
    localparam int unsigned FT = 40;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_busy;
    logic       busy;
    logic       err;

    uart_ahb_loader_if ahb();

    uart_ahb_loader #(.FRAME_TIMEOUT(FT)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .ahb(ahb),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
        .busy(busy), .err(err)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        int          dplen;
        int          aplen;
    } txn_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          ws;
        int          aws;
        bit          berr;
        int          txlen;
        logic [31:0] exp_haddr;
        int          exp_dplen;
        int          exp_nrep;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    txn_t exp_txn[$];
    logic [7:0] exp_tx[$];
    int cfg_ws = 0;
    int cfg_aws = 0;
    bit cfg_berr = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;
    int cfg_txlen = 1;
    bit first_pending = 1'b0;
    int first_cyc = 0;
    int err_cnt = 0;
    int txn_cnt = 0;
    int tx_cnt = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic slave_done(input logic [31:0] a, input bit w, input int dlen, input int alen);
        txn_t t;
        if (exp_txn.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_txn: got addr %h expected none", a);
        end else begin
            t = exp_txn.pop_front();
            check("haddr", a, t.addr);
            check("hwrite", 32'(w), 32'(t.wr));
            if (t.wr) check("hwdata", ahb.HWDATA, t.wdata);
            check("data_phase_len", 32'(dlen), 32'(t.dplen));
            check("addr_phase_len", 32'(alen), 32'(t.aplen));
        end
        txn_cnt++;
        first_pending = 1'b1;
        first_cyc = cyc + 1;
    endtask

    // AHB slave model: optional address-phase stalls, wait states, two-cycle ERROR.
    initial begin
        bit dp;
        int di;
        int ai;
        int ap;
        bit aw;
        logic [31:0] a0;
        dp = 1'b0; di = 0; ai = 0; ap = 0; aw = 1'b0; a0 = 32'h0;
        ahb.HREADY = 1'b1; ahb.HRESP = 1'b0; ahb.HRDATA = 32'h0;
        forever begin
            @(posedge HCLK);
            #1;
            if (HRESETn !== 1'b1) begin
                dp = 1'b0; di = 0; ai = 0;
                ahb.HREADY = 1'b1; ahb.HRESP = 1'b0;
            end else if (dp) begin
                check("htrans_idle_in_data", 32'(ahb.HTRANS), 32'h0);
                if (cfg_berr && di == 0) begin
                    ahb.HREADY = 1'b0; ahb.HRESP = 1'b1; di++;
                end else if (cfg_berr) begin
                    ahb.HREADY = 1'b1; ahb.HRESP = 1'b1; di++;
                    slave_done(a0, aw, di, ap);
                    dp = 1'b0;
                end else if (di < cfg_ws) begin
                    ahb.HREADY = 1'b0; ahb.HRESP = 1'b0; di++;
                end else begin
                    ahb.HREADY = 1'b1; ahb.HRESP = 1'b0; ahb.HRDATA = cfg_rdata; di++;
                    slave_done(a0, aw, di, ap);
                    dp = 1'b0;
                end
            end else if (ahb.HTRANS == 2'b10) begin
                if (ai == 0) begin
                    a0 = ahb.HADDR;
                    aw = ahb.HWRITE;
                end else begin
                    check("haddr_held", ahb.HADDR, a0);
                    check("hwrite_held", 32'(ahb.HWRITE), 32'(aw));
                end
                ai++;
                if (ai <= cfg_aws) begin
                    ahb.HREADY = 1'b0;
                end else begin
                    ahb.HREADY = 1'b1;
                    ap = ai; ai = 0; dp = 1'b1; di = 0;
                end
            end else begin
                ahb.HREADY = 1'b1; ahb.HRESP = 1'b0;
            end
        end
    end

    // UART transmitter model and reply scoreboard.
    initial begin
        int bc;
        bit prev;
        logic [7:0] held;
        tx_busy = 1'b0; bc = 0; prev = 1'b0; held = 8'h00;
        forever begin
            @(posedge HCLK);
            #1;
            if (HRESETn !== 1'b1) begin
                tx_busy = 1'b0; bc = 0; prev = 1'b0;
            end else begin
                if (tx_en === 1'b1) begin
                    tx_cnt++;
                    check("tx_en_back_to_back", 32'(prev), 32'h0);
                    check("tx_en_while_busy", 32'(tx_busy), 32'h0);
                    if (exp_tx.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_tx: got %h expected none", tx_data);
                    end else begin
                        check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                    end
                    if (first_pending) begin
                        check("first_tx_latency", 32'(cyc), 32'(first_cyc));
                        first_pending = 1'b0;
                    end
                    held = tx_data;
                    if (cfg_txlen > 0) begin
                        tx_busy = 1'b1;
                        bc = cfg_txlen;
                    end
                end else if (bc > 0) begin
                    check("tx_data_stable", 32'(tx_data), 32'(held));
                    bc--;
                    if (bc == 0) tx_busy = 1'b0;
                end
                prev = tx_en;
            end
        end
    end

    // err pulse counter.
    initial begin
        forever begin
            @(posedge HCLK);
            #1;
            if (err === 1'b1) err_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tick(gap);
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || tx_busy || exp_tx.size() != 0) && n < 600) begin
            tick(1);
            n++;
        end
        check(name, 32'(n < 600), 32'h1);
        tick(2);
    endtask

    task automatic send_frame(input vec_t v);
        send_byte(v.wr ? 8'h57 : 8'h52, 1);
        for (int i = 3; i >= 0; i--)
            send_byte(v.addr[8*i +: 8], (v.wr || i > 0) ? 1 + (i % 2) : 0);
        if (v.wr)
            for (int i = 3; i >= 0; i--)
                send_byte(v.data[8*i +: 8], (i > 0) ? 1 : 0);
    endtask

    task automatic run_vec(input vec_t v, input bit inject);
        int e0;
        int t0;
        int n0;
        cfg_ws = v.ws; cfg_aws = v.aws; cfg_berr = v.berr;
        cfg_rdata = v.data; cfg_txlen = v.txlen;
        exp_txn.push_back('{v.exp_haddr, v.wr, v.data, v.exp_dplen, v.aws + 1});
        if (v.berr) exp_tx.push_back(8'h45);
        else if (v.wr) exp_tx.push_back(8'h4B);
        else for (int i = 3; i >= 0; i--) exp_tx.push_back(v.data[8*i +: 8]);
        e0 = err_cnt; t0 = tx_cnt; n0 = txn_cnt;
        send_frame(v);
        check("nonseq_after_last_byte", 32'(ahb.HTRANS), 32'h2);
        check("busy_in_addr_phase", 32'(busy), 32'h1);
        if (inject) begin
            tick(2);
            send_byte(8'h57, 0);
            send_byte(8'h52, 0);
        end
        wait_quiet("frame_completes");
        check("err_pulses", 32'(err_cnt - e0), 32'(v.berr));
        check("reply_count", 32'(tx_cnt - t0), 32'(v.exp_nrep));
        check("txn_count", 32'(txn_cnt - n0), 32'h1);
        check("busy_after_frame", 32'(busy), 32'h0);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t v;
        int n0;
        int t0;
        HRESETn = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tick(3);
        check("rst_htrans", 32'(ahb.HTRANS), 32'h0);
        check("rst_haddr", ahb.HADDR, 32'h0);
        check("rst_hwrite", 32'(ahb.HWRITE), 32'h0);
        check("rst_hwdata", ahb.HWDATA, 32'h0);
        check("rst_tx_en", 32'(tx_en), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("hsize", 32'(ahb.HSIZE), 32'h2);
        check("hburst", 32'(ahb.HBURST), 32'h0);
        check("hprot", 32'(ahb.HPROT), 32'h3);
        check("hmastlock", 32'(ahb.HMASTLOCK), 32'h0);
        HRESETn = 1'b1;
        tick(2);

        //            wr    addr          data          ws aws berr txlen exp_haddr     dp nrep
        vecs[0] = '{1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 1'b0, 3, 32'h0000_0104, 1, 1};
        vecs[1] = '{1'b0, 32'h2000_0007, 32'h1234_5678, 3, 0, 1'b0, 4, 32'h2000_0004, 4, 4};
        vecs[2] = '{1'b1, 32'h1000_0010, 32'h0BAD_F00D, 0, 0, 1'b1, 2, 32'h1000_0010, 2, 1};
        vecs[3] = '{1'b0, 32'hA5A5_A5A6, 32'hCAFE_F00D, 1, 2, 1'b0, 0, 32'hA5A5_A5A4, 2, 4};
        vecs[4] = '{1'b0, 32'h0000_0003, 32'h55AA_55AA, 2, 0, 1'b1, 1, 32'h0000_0000, 2, 1};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 1'b0, 5, 32'hFFFF_FFFC, 1, 1};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, 1, 32'h8000_0000, 1, 4};
        for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0);

        // Junk bytes in IDLE are discarded.
        n0 = txn_cnt;
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        check("junk_busy", 32'(busy), 32'h0);
        check("junk_no_txn", 32'(txn_cnt - n0), 32'h0);
        run_vec(vecs[1], 1'b0);

        // Partial frame abandoned after the timeout, then a read works.
        n0 = txn_cnt;
        send_byte(8'h57, 1);
        send_byte(8'h00, 1);
        send_byte(8'h00, 0);
        tick(FT - 6);
        check("timeout_still_busy", 32'(busy), 32'h1);
        tick(12);
        check("timeout_idle", 32'(busy), 32'h0);
        check("timeout_no_txn", 32'(txn_cnt - n0), 32'h0);
        run_vec(vecs[6], 1'b0);

        // Bytes arriving during the data phase are dropped.
        v = '{1'b0, 32'h0000_4444, 32'h0102_0304, 4, 0, 1'b0, 2, 32'h0000_4444, 5, 4};
        run_vec(v, 1'b1);

        // Reset in the middle of a read data phase.
        cfg_ws = 6; cfg_aws = 0; cfg_berr = 1'b0; cfg_rdata = 32'h7777_7777; cfg_txlen = 2;
        v = '{1'b0, 32'h0000_0800, 32'h7777_7777, 6, 0, 1'b0, 2, 32'h0000_0800, 7, 4};
        send_frame(v);
        tick(3);
        #3;
        HRESETn = 1'b0;
        #1;
        check("rst_mid_htrans", 32'(ahb.HTRANS), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_tx_en", 32'(tx_en), 32'h0);
        exp_txn.delete();
        exp_tx.delete();
        first_pending = 1'b0;
        @(posedge HCLK);
        #1;
        tick(2);
        HRESETn = 1'b1;
        t0 = tx_cnt;
        tick(20);
        check("rst_mid_no_tx", 32'(tx_cnt - t0), 32'h0);
        check("rst_mid_idle", 32'(busy), 32'h0);
        run_vec(vecs[0], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
